// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: core request/ack and data-memory command bus of the arbiter.
interface dm_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [3:0]          core_status;
    logic [3:0]          req;
    logic [3:0]          req_we;
    logic [4*ADDR_W-1:0] req_addr;
    logic [4*DATA_W-1:0] req_wdata;
    logic [3:0]          grant;
    logic [3:0]          ack;
    logic [DATA_W-1:0]   rdata;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                busy;

    modport slave (
        input  core_status, req, req_we, req_addr, req_wdata, mem_rdata,
        output grant, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output core_status, req, req_we, req_addr, req_wdata, mem_rdata,
        input  grant, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: 4-core data-memory arbiter, two cycles per access, round-robin;
// define DM_ARB_FIXED_PRIO_EN for fixed priority (core 0 highest).
module dm_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input logic          clk,
    input logic          rst,
    dm_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [3:0]          grant_q, grant_d;
    logic [3:0]          ack_q, ack_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]          elig;
    logic [1:0]          base, idx, win;

    always_comb begin
        // the core being acked this cycle may only re-request from the next cycle
        elig = bus.req & bus.core_status & ~ack_q;
`ifdef DM_ARB_FIXED_PRIO_EN
        base = 2'd0;
`else
        base = ptr_q;
`endif
        idx = 2'd0;
        win = 2'd0;
        // descending scan so the eligible core closest to base wins
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (elig[idx]) win = idx;
        end
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = 4'b0000;
        ack_d       = 4'b0000;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_q == GRANT) begin
            state_d = RESP;
            ack_d   = grant_q;
        end else if (|elig) begin
            state_d     = GRANT;
            grant_d     = 4'b0001 << win;
            mem_en_d    = 1'b1;
            mem_we_d    = bus.req_we[win];
            mem_addr_d  = bus.req_addr[win*ADDR_W +: ADDR_W];
            mem_wdata_d = bus.req_wdata[win*DATA_W +: DATA_W];
`ifndef DM_ARB_FIXED_PRIO_EN
            ptr_d       = win + 2'd1;
`endif
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            grant_q     <= 4'b0000;
            ack_q       <= 4'b0000;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a small synchronous memory model.
module tb_dm_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic preload = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [15:0] mem [256];

    dm_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    dm_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) mem[8'h10] <= 16'h1234;
        else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // order packs the expected winner index of access i at bits [2*(i%4) +: 2]
    task automatic stream(input string tag, input logic [3:0] st, input logic [3:0] rq,
                          input logic [7:0] order, input int n);
        logic [1:0] w;
        rst = 1'b1;
        bus.core_status = st;
        bus.req = rq;
        tick();
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = order[2*(i%4) +: 2];
            tick();
            chk({tag, "_grant"}, 32'(bus.grant), 32'(4'b0001 << w));
            chk({tag, "_busy_g"}, 32'(bus.busy), 32'd1);
            tick();
            chk({tag, "_ack"}, 32'(bus.ack), 32'(4'b0001 << w));
            chk({tag, "_grant0"}, 32'(bus.grant), 32'd0);
            chk({tag, "_busy_r"}, 32'(bus.busy), 32'd1);
        end
        rst = 1'b1;
        bus.req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.core_status = 4'b0000;
        bus.req = 4'b0000;
        bus.req_we = 4'b0000;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        #1 rst = 1'b1;
        #2;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        tick();
        preload = 1'b0;
        tick();
        rst = 1'b0;
        // single read by core 0
        bus.core_status = 4'b0001;
        bus.req = 4'b0001;
        bus.req_addr[15:0] = 16'h0010;
        tick();
        chk("rd_grant", 32'(bus.grant), 32'h1);
        chk("rd_mem_en", 32'(bus.mem_en), 32'd1);
        chk("rd_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rd_mem_addr", 32'(bus.mem_addr), 32'h0010);
        chk("rd_ack_early", 32'(bus.ack), 32'd0);
        tick();
        chk("rd_ack", 32'(bus.ack), 32'h1);
        chk("rd_grant0", 32'(bus.grant), 32'd0);
        chk("rd_mem_en0", 32'(bus.mem_en), 32'd0);
        chk("rd_rdata", 32'(bus.rdata), 32'h1234);
        bus.req = 4'b0000;
        tick();
        chk("rd_ack_done", 32'(bus.ack), 32'd0);
        chk("rd_idle", 32'(bus.busy), 32'd0);
        // core 2 writes, core 0 reads it back
        bus.core_status = 4'b1111;
        bus.req = 4'b0100;
        bus.req_we = 4'b0100;
        bus.req_addr[47:32] = 16'h0042;
        bus.req_wdata[47:32] = 16'hBEEF;
        tick();
        chk("wr_grant", 32'(bus.grant), 32'h4);
        chk("wr_mem_we", 32'(bus.mem_we), 32'd1);
        chk("wr_mem_addr", 32'(bus.mem_addr), 32'h0042);
        chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
        bus.req = 4'b0000;
        bus.req_we = 4'b0000;
        tick();
        chk("wr_ack", 32'(bus.ack), 32'h4);
        chk("wr_mem_we0", 32'(bus.mem_we), 32'd0);
        chk("wr_mem_en0", 32'(bus.mem_en), 32'd0);
        bus.req = 4'b0001;
        bus.req_addr[15:0] = 16'h0042;
        tick();
        chk("rb_grant", 32'(bus.grant), 32'h1);
        chk("rb_mem_addr", 32'(bus.mem_addr), 32'h0042);
        tick();
        chk("rb_ack", 32'(bus.ack), 32'h1);
        chk("rb_rdata", 32'(bus.rdata), 32'hBEEF);
        bus.req = 4'b0000;
        tick();
        chk("rb_idle", 32'(bus.busy), 32'd0);
        // reset during the grant cycle of core 1
        bus.req = 4'b0010;
        tick();
        chk("ab_grant", 32'(bus.grant), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("ab_grant0", 32'(bus.grant), 32'd0);
        chk("ab_mem_en0", 32'(bus.mem_en), 32'd0);
        chk("ab_mem_addr0", 32'(bus.mem_addr), 32'd0);
        chk("ab_mem_wdata0", 32'(bus.mem_wdata), 32'd0);
        chk("ab_busy0", 32'(bus.busy), 32'd0);
        tick();
        chk("ab_no_ack", 32'(bus.ack), 32'd0);
        rst = 1'b0;
        bus.req = 4'b1010;
        tick();
        chk("ab_first_grant", 32'(bus.grant), 32'h2);
        chk("ab_first_noack", 32'(bus.ack), 32'd0);
        tick();
        chk("ab_ack1", 32'(bus.ack), 32'h2);
        chk("ab_ack1_grant0", 32'(bus.grant), 32'd0);
        bus.req = 4'b1000;
        tick();
        chk("ab_grant3", 32'(bus.grant), 32'h8);
        chk("ab_grant3_ack0", 32'(bus.ack), 32'd0);
        tick();
        chk("ab_ack3", 32'(bus.ack), 32'h8);
        bus.req = 4'b0000;
        tick();
        chk("ab_idle", 32'(bus.busy), 32'd0);
`ifndef DM_ARB_FIXED_PRIO_EN
        stream("rr_all", 4'b1111, 4'b1111, 8'b11_10_01_00, 5);
        stream("rr_mask", 4'b0011, 4'b1111, 8'b01_00_01_00, 4);
        stream("rr_03", 4'b1111, 4'b1001, 8'b11_00_11_00, 4);
`else
        stream("fp_first", 4'b1111, 4'b1001, 8'b00_00_00_00, 1);
`endif
        // all cores disabled: nothing is granted
        rst = 1'b1;
        bus.core_status = 4'b0000;
        bus.req = 4'b1111;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("off_grant", 32'(bus.grant), 32'd0);
            chk("off_busy", 32'(bus.busy), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
